mem_port_arbiter: RTL and testbench

Shares the processor's single-ported Memory block between the instruction-fetch requester and the data (load/store) requester. Round-robin arbitration, one access in flight, registered response delivery. Write suppression and a sticky fault report when Memory flags an access violation via AccInv. Sits between the fetch/execute control and the Memory instance, driving Memory's Addr/WriteData/WriteFlag/KernelFlag.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 16 +
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic        REQ_IF   = 1'b0;
  localparam logic        REQ_D    = 1'b1;
  localparam logic [15:0] ERR_DATA = 16'h0000;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] pick,
  output logic       upd
);
  assign pick[REQ_IF] = en && req_if && (!req_d || last_gnt == REQ_D);
  assign pick[REQ_D]  = en && req_d  && (!req_if || last_gnt == REQ_IF);
  assign upd          = |pick;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported Memory between fetch and load/store requesters:
// one access in flight, IDLE -> ISSUE -> WAIT, registered responses, sticky fault.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          IfReq,
  input  logic [AW-1:0] IfAddr,
  output logic          IfGnt,
  output logic          IfValid,
  output logic [DW-1:0] IfData,
  input  logic          DReq,
  input  logic          DWrite,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DGnt,
  output logic          DValid,
  output logic [DW-1:0] DRData,
  output logic          RespErr,
  input  logic          KernelMode,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWriteData,
  output logic          MemWriteFlag,
  output logic          MemKernelFlag,
  input  logic [DW-1:0] MemReadData,
  input  logic          MemAccInv,
  output logic          Fault,
  output logic [AW-1:0] FaultAddr,
  output logic          FaultSrc,
  input  logic          FaultClr
);
  state_e        state;
  logic          win, last_gnt, wr_bit, err;
  logic [1:0]    pick;
  logic          upd, fault_set;
  logic [DW-1:0] resp_data;

  rr_arb2 u_arb (
    .req_if   (IfReq),
    .req_d    (DReq),
    .last_gnt (last_gnt),
    .en       (state == IDLE && !Fault),
    .pick     (pick),
    .upd      (upd)
  );

  // Gated by the live violation flag so a faulted store never reaches the array.
  assign MemWriteFlag = (state == ISSUE) && wr_bit && !MemAccInv;
  assign fault_set    = (state == ISSUE) && MemAccInv;
  assign resp_data    = (err || wr_bit) ? DW'(ERR_DATA) : MemReadData;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      win           <= REQ_IF;
      last_gnt      <= REQ_D;
      wr_bit        <= 1'b0;
      err           <= 1'b0;
      IfGnt         <= 1'b0;
      DGnt          <= 1'b0;
      IfValid       <= 1'b0;
      DValid        <= 1'b0;
      RespErr       <= 1'b0;
      IfData        <= '0;
      DRData        <= '0;
      MemAddr       <= '0;
      MemWriteData  <= '0;
      MemKernelFlag <= 1'b0;
      Fault         <= 1'b0;
      FaultAddr     <= '0;
      FaultSrc      <= REQ_IF;
    end else begin
      IfGnt   <= 1'b0;
      DGnt    <= 1'b0;
      IfValid <= 1'b0;
      DValid  <= 1'b0;
      RespErr <= 1'b0;

      // A new fault beats a simultaneous clear; the first unacknowledged one is kept.
      if (fault_set) begin
        Fault <= 1'b1;
        if (!Fault || FaultClr) begin
          FaultAddr <= MemAddr;
          FaultSrc  <= win;
        end
      end else if (FaultClr) begin
        Fault <= 1'b0;
      end

      case (state)
        IDLE: if (upd) begin
          win           <= pick[REQ_D];
          last_gnt      <= pick[REQ_D];
          MemAddr       <= pick[REQ_D] ? DAddr : IfAddr;
          MemWriteData  <= pick[REQ_D] ? DWData : '0;
          wr_bit        <= pick[REQ_D] && DWrite;
          MemKernelFlag <= KernelMode;
          IfGnt         <= pick[REQ_IF];
          DGnt          <= pick[REQ_D];
          state         <= ISSUE;
        end
        ISSUE: begin
          err   <= MemAccInv;
          state <= WAIT;
        end
        WAIT: begin
          if (win == REQ_D) begin
            DRData <= resp_data;
            DValid <= 1'b1;
          end else begin
            IfData  <= resp_data;
            IfValid <= 1'b1;
          end
          RespErr <= err;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a Memory stub that faults on
// Addr[15]=1 in user mode.
module tb_mem_port_arbiter;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        IfReq = 1'b0, DReq = 1'b0, DWrite = 1'b0, KernelMode = 1'b0, FaultClr = 1'b0;
  logic [15:0] IfAddr = '0, DAddr = '0, DWData = '0;
  logic        IfGnt, IfValid, DGnt, DValid, RespErr;
  logic [15:0] IfData, DRData, MemAddr, MemWriteData, MemReadData, FaultAddr;
  logic        MemWriteFlag, MemKernelFlag, MemAccInv, Fault, FaultSrc;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(16), .DW(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt), .IfValid(IfValid), .IfData(IfData),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DGnt(DGnt), .DValid(DValid), .DRData(DRData), .RespErr(RespErr),
    .KernelMode(KernelMode),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWriteFlag(MemWriteFlag),
    .MemKernelFlag(MemKernelFlag), .MemReadData(MemReadData), .MemAccInv(MemAccInv),
    .Fault(Fault), .FaultAddr(FaultAddr), .FaultSrc(FaultSrc), .FaultClr(FaultClr)
  );

  always #5 Clk = ~Clk;

  // Memory stub: synchronous read, write on WriteFlag, combinational violation.
  logic [15:0] mem [0:65535];
  logic [15:0] mem_rdata;
  assign MemAccInv   = MemAddr[15] & ~MemKernelFlag;
  assign MemReadData = mem_rdata;
  always @(posedge Clk) begin
    if (MemWriteFlag) mem[MemAddr] <= MemWriteData;
    mem_rdata <= mem[MemAddr];
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Runs one request to completion; reports grant/valid latency in cycles
  // (-1 when never seen), response data/error and whether a write strobe appeared.
  task automatic access(input logic src, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, output int glat, output int vlat,
                        output logic [15:0] rd, output logic re, output logic wf);
    glat = -1; vlat = -1; rd = 16'hxxxx; re = 1'bx; wf = 1'b0;
    if (src) begin DReq = 1'b1; DWrite = wr; DAddr = addr; DWData = wd; end
    else     begin IfReq = 1'b1; IfAddr = addr; end
    for (int n = 1; n <= 20 && vlat < 0; n++) begin
      tick();
      if (MemWriteFlag) wf = 1'b1;
      if ((src ? DGnt : IfGnt) && glat < 0) begin
        glat = n;
        if (src) DReq = 1'b0; else IfReq = 1'b0;
      end
      if (src ? DValid : IfValid) begin
        vlat = n; rd = src ? DRData : IfData; re = RespErr;
      end
    end
    DReq = 1'b0; IfReq = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({IfGnt, DGnt, IfValid, DValid, RespErr, MemWriteFlag, Fault, FaultSrc, MemKernelFlag} !== 9'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000000",
               {IfGnt, DGnt, IfValid, DValid, RespErr, MemWriteFlag, Fault, FaultSrc, MemKernelFlag});
    end
    total++;
    if ({MemAddr, MemWriteData, FaultAddr, IfData, DRData} !== 80'h0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h %h want=0", MemAddr, MemWriteData, FaultAddr, IfData, DRData);
    end
    Rst_n = 1'b1;
    tick();
    total++;
    if ({IfGnt, DGnt} !== 2'b00) begin bad++; $display("FAIL idle_no_gnt got=%b want=00", {IfGnt, DGnt}); end
  endtask

  task automatic test_store_load;
    int g, v; logic [15:0] rd; logic re, wf;
    access(1'b1, 1'b1, 16'h4000, 16'h1234, g, v, rd, re, wf);
    total++; if (g !== 1) begin bad++; $display("FAIL st_gnt_lat got=%0d want=1", g); end
    total++; if (wf !== 1'b1) begin bad++; $display("FAIL st_wflag got=%b want=1", wf); end
    total++; if (v !== 3 || re !== 1'b0) begin bad++; $display("FAIL st_valid got=%0d/%b want=3/0", v, re); end
    access(1'b1, 1'b0, 16'h4000, 16'h0000, g, v, rd, re, wf);
    total++; if (g !== 1) begin bad++; $display("FAIL ld_gnt_lat got=%0d want=1", g); end
    total++; if (v !== 3) begin bad++; $display("FAIL ld_valid_lat got=%0d want=3", v); end
    total++; if (rd !== 16'h1234 || re !== 1'b0) begin bad++; $display("FAIL ld_data got=%h/%b want=1234/0", rd, re); end
    total++; if (wf !== 1'b0) begin bad++; $display("FAIL ld_wflag got=%b want=0", wf); end
  endtask

  task automatic test_arbitration;
    int if1, if2, d1; logic [15:0] fd, dd, fd2;
    if1 = -1; if2 = -1; d1 = -1; fd = 16'hxxxx; dd = 16'hxxxx; fd2 = 16'hxxxx;
    Rst_n = 1'b0; tick(); Rst_n = 1'b1;
    IfReq = 1'b1; IfAddr = 16'h4000; DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h4000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (IfGnt) begin if (if1 < 0) if1 = c; else if2 = c; end
      if (DGnt && d1 < 0) d1 = c;
      if (IfValid && c == 3) fd = IfData;
      if (DValid && c == 6) dd = DRData;
      if (IfValid && c == 9) fd2 = IfData;
      if (c == 8) begin IfReq = 1'b0; DReq = 1'b0; end
    end
    total++; if (if1 !== 1) begin bad++; $display("FAIL tie_first_if got=%0d want=1", if1); end
    total++; if (d1 !== 4) begin bad++; $display("FAIL tie_then_d got=%0d want=4", d1); end
    total++; if (if2 !== 7) begin bad++; $display("FAIL tie_then_if got=%0d want=7", if2); end
    total++;
    if (fd !== 16'h1234 || dd !== 16'h1234 || fd2 !== 16'h1234) begin
      bad++; $display("FAIL tie_data got=%h %h %h want=1234 1234 1234", fd, dd, fd2);
    end
  endtask

  task automatic test_back_to_back;
    int g1, g2, v; logic [15:0] rd; logic re, wf;
    access(1'b1, 1'b1, 16'h0020, 16'h0A0A, g1, v, rd, re, wf);
    access(1'b0, 1'b0, 16'h0020, 16'h0000, g2, v, rd, re, wf);
    total++; if (g1 !== 1 || g2 !== 1) begin bad++; $display("FAIL b2b_gnt got=%0d/%0d want=1/1", g1, g2); end
    total++; if (rd !== 16'h0A0A || re !== 1'b0) begin bad++; $display("FAIL b2b_fetch got=%h/%b want=0a0a/0", rd, re); end
  endtask

  task automatic test_kernel;
    int g, v; logic [15:0] rd; logic re, wf;
    KernelMode = 1'b1;
    access(1'b1, 1'b1, 16'h8002, 16'hCAFE, g, v, rd, re, wf);
    total++; if (wf !== 1'b1 || re !== 1'b0) begin bad++; $display("FAIL kst got=wf%b/err%b want=1/0", wf, re); end
    access(1'b1, 1'b0, 16'h8002, 16'h0000, g, v, rd, re, wf);
    total++; if (rd !== 16'hCAFE || re !== 1'b0) begin bad++; $display("FAIL kld got=%h/%b want=cafe/0", rd, re); end
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL k_nofault got=%b want=0", Fault); end
    KernelMode = 1'b0;
  endtask

  task automatic test_fault_store;
    int g, v, gn; logic [15:0] rd; logic re, wf;
    access(1'b1, 1'b1, 16'h8002, 16'hBEEF, g, v, rd, re, wf);
    total++; if (wf !== 1'b0) begin bad++; $display("FAIL fst_wflag got=%b want=0", wf); end
    total++; if (v !== 3 || re !== 1'b1 || rd !== 16'h0000) begin
      bad++; $display("FAIL fst_resp got=%0d/%b/%h want=3/1/0000", v, re, rd);
    end
    total++; if (Fault !== 1'b1 || FaultAddr !== 16'h8002 || FaultSrc !== 1'b1) begin
      bad++; $display("FAIL fst_fault got=%b/%h/%b want=1/8002/1", Fault, FaultAddr, FaultSrc);
    end
    gn = 0;
    IfReq = 1'b1; IfAddr = 16'h0020;
    repeat (6) begin tick(); if (IfGnt) gn++; end
    total++; if (gn !== 0) begin bad++; $display("FAIL stall_gnts got=%0d want=0", gn); end
    FaultClr = 1'b1; tick(); FaultClr = 1'b0;
    total++; if (Fault !== 1'b0 || IfGnt !== 1'b0) begin bad++; $display("FAIL clr got=%b/%b want=0/0", Fault, IfGnt); end
    tick();
    total++; if (IfGnt !== 1'b1) begin bad++; $display("FAIL post_clr_gnt got=%b want=1", IfGnt); end
    IfReq = 1'b0;
    repeat (2) tick();
    total++; if (IfValid !== 1'b1 || IfData !== 16'h0A0A) begin
      bad++; $display("FAIL post_clr_fetch got=%b/%h want=1/0a0a", IfValid, IfData);
    end
    KernelMode = 1'b1;
    access(1'b1, 1'b0, 16'h8002, 16'h0000, g, v, rd, re, wf);
    KernelMode = 1'b0;
    total++; if (rd !== 16'hCAFE) begin bad++; $display("FAIL fst_suppressed got=%h want=cafe", rd); end
  endtask

  task automatic test_fault_clr_same;
    IfReq = 1'b1; IfAddr = 16'h9000; FaultClr = 1'b1;
    tick();
    total++; if (IfGnt !== 1'b1) begin bad++; $display("FAIL same_gnt got=%b want=1", IfGnt); end
    IfReq = 1'b0;
    tick();
    total++; if (Fault !== 1'b1 || FaultAddr !== 16'h9000 || FaultSrc !== 1'b0) begin
      bad++; $display("FAIL same_fault got=%b/%h/%b want=1/9000/0", Fault, FaultAddr, FaultSrc);
    end
    FaultClr = 1'b0;
    tick();
    total++; if (IfValid !== 1'b1 || RespErr !== 1'b1 || IfData !== 16'h0000) begin
      bad++; $display("FAIL same_resp got=%b/%b/%h want=1/1/0000", IfValid, RespErr, IfData);
    end
    FaultClr = 1'b1; tick(); FaultClr = 1'b0;
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL same_clr got=%b want=0", Fault); end
  endtask

  task automatic test_reset_mid;
    int g, v, vs; logic [15:0] rd; logic re, wf;
    vs = 0;
    DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h4000; DWData = 16'hDEAD;
    tick();
    total++; if (DGnt !== 1'b1 || MemWriteFlag !== 1'b1) begin
      bad++; $display("FAIL mid_issue got=%b/%b want=1/1", DGnt, MemWriteFlag);
    end
    Rst_n = 1'b0; DReq = 1'b0;
    #1;
    total++; if (MemWriteFlag !== 1'b0 || DGnt !== 1'b0) begin
      bad++; $display("FAIL mid_abort got=%b/%b want=0/0", MemWriteFlag, DGnt);
    end
    repeat (2) begin tick(); if (DValid) vs++; end
    total++;
    if ({DValid, RespErr, Fault, MemWriteFlag, MemKernelFlag} !== 5'b0 || {MemAddr, MemWriteData, DRData, IfData} !== 64'h0) begin
      bad++; $display("FAIL mid_reset_vals got=%b %h %h %h %h want=0",
                      {DValid, RespErr, Fault, MemWriteFlag, MemKernelFlag}, MemAddr, MemWriteData, DRData, IfData);
    end
    Rst_n = 1'b1;
    repeat (2) begin tick(); if (DValid) vs++; end
    total++; if (vs !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", vs); end
    access(1'b1, 1'b0, 16'h4000, 16'h0000, g, v, rd, re, wf);
    total++; if (rd !== 16'h1234 || re !== 1'b0) begin bad++; $display("FAIL mid_prior got=%h/%b want=1234/0", rd, re); end
  endtask

  initial begin
    #1;
    test_reset();
    test_store_load();
    test_arbitration();
    test_back_to_back();
    test_kernel();
    test_fault_store();
    test_fault_clr_same();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
